// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register with branch/jump/jump-register selection,
// byte-wide program loader, big-endian word fetch and an IDLE/RUN/HALTED run-control FSM.
module if_fetch_unit #(
    parameter int                NB_REG    = 32,
    parameter int                NB_ADDR   = 9,
    parameter int                NB_INST   = 26,
    parameter logic [NB_REG-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dunit_clk_en,
    input  logic               i_start,
    input  logic               i_clear,
    input  logic               i_load_valid,
    input  logic [7:0]         i_load_byte,
    output logic               o_load_ready,
    output logic               o_load_full,
    output logic [NB_ADDR:0]   o_load_count,
    input  logic               i_PCSrc,
    input  logic               i_Jump,
    input  logic               i_JSel,
    input  logic               i_PCWrite,
    input  logic [NB_REG-1:0]  i_inmed,
    input  logic [NB_INST-1:0] i_inst_to_mxp,
    input  logic [NB_REG-1:0]  i_pc_jsel,
    output logic [NB_REG-1:0]  o_pc,
    output logic [NB_REG-1:0]  o_pcplus4,
    output logic [NB_REG-1:0]  o_instruction,
    output logic               o_halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t              state, state_next;
    logic [NB_REG-1:0]   pc, pc_next, pc_plus4, pc_sel, pc_target, jump_target;
    logic [NB_ADDR:0]    ptr;
    logic [7:0]          mem [2**NB_ADDR];
    logic [NB_ADDR-1:0]  addr;
    logic [31:0]         word;
    logic                load_accept;
    logic                advance;

    assign pc_plus4     = pc + NB_REG'(4);
    assign o_pc         = pc;
    assign o_pcplus4    = pc_plus4;
    assign o_halted     = (state == S_HALTED);
    assign o_load_full  = ptr[NB_ADDR];
    assign o_load_count = ptr;
    assign o_load_ready = (state == S_IDLE) & ~o_load_full;

    // A reset or clear in the same cycle as a valid byte wins; the byte is dropped.
    assign load_accept  = i_load_valid & o_load_ready & ~i_reset & ~i_clear;
    assign advance      = i_dunit_clk_en & i_PCWrite;

    // Byte address wraps modulo RAM depth; high PC bits simply alias.
    assign addr = pc[NB_ADDR-1:0];
    assign word = {mem[addr], mem[addr + NB_ADDR'(1)],
                   mem[addr + NB_ADDR'(2)], mem[addr + NB_ADDR'(3)]};
    assign o_instruction = (state == S_RUN) ? NB_REG'(word) : '0;

    assign jump_target = {pc_plus4[NB_REG-1:NB_INST+2], i_inst_to_mxp, 2'b00};

    always_comb begin
        pc_sel = pc_plus4;
        if (i_JSel)
            pc_sel = i_pc_jsel;
        else if (i_Jump)
            pc_sel = jump_target;
        else if (i_PCSrc)
            pc_sel = i_inmed;
        pc_target = {pc_sel[NB_REG-1:2], 2'b00};
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            S_IDLE: begin
                if (i_start)
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (advance) begin
                    if (word == HALT_WORD)
                        state_next = S_HALTED;
                    else
                        pc_next = pc_target;
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ptr   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load_accept)
                ptr <= ptr + (NB_ADDR+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (load_accept)
            mem[ptr[NB_ADDR-1:0]] <= i_load_byte;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit (16-byte RAM): directed scenarios with literal expectations
// plus randomized load/run rounds checked every cycle against a behavioural model.
module tb_if_fetch_unit;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0, i_dunit_clk_en = 1'b0, i_start = 1'b0, i_clear = 1'b0;
    logic        i_load_valid = 1'b0;
    logic [7:0]  i_load_byte = '0;
    logic        i_PCSrc = 1'b0, i_Jump = 1'b0, i_JSel = 1'b0, i_PCWrite = 1'b0;
    logic [31:0] i_inmed = '0, i_pc_jsel = '0;
    logic [25:0] i_inst_to_mxp = '0;
    logic        o_load_ready, o_load_full, o_halted;
    logic [4:0]  o_load_count;
    logic [31:0] o_pc, o_pcplus4, o_instruction;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .NB_REG   (32),
        .NB_ADDR  (4),
        .NB_INST  (26),
        .RESET_PC (32'h0),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_dunit_clk_en(i_dunit_clk_en),
        .i_start       (i_start),
        .i_clear       (i_clear),
        .i_load_valid  (i_load_valid),
        .i_load_byte   (i_load_byte),
        .o_load_ready  (o_load_ready),
        .o_load_full   (o_load_full),
        .o_load_count  (o_load_count),
        .i_PCSrc       (i_PCSrc),
        .i_Jump        (i_Jump),
        .i_JSel        (i_JSel),
        .i_PCWrite     (i_PCWrite),
        .i_inmed       (i_inmed),
        .i_inst_to_mxp (i_inst_to_mxp),
        .i_pc_jsel     (i_pc_jsel),
        .o_pc          (o_pc),
        .o_pcplus4     (o_pcplus4),
        .o_instruction (o_instruction),
        .o_halted      (o_halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run mode flags, PC, load pointer, shadow RAM with written flags.
    bit          m_on = 1'b0;
    bit          m_running = 1'b0, m_halted = 1'b0;
    logic [31:0] m_pc = '0;
    int          m_ptr = 0;
    logic [7:0]  m_mem [DEPTH];
    bit          m_known [DEPTH];

    function automatic bit m_word_known(input logic [31:0] pc);
        int unsigned a = int'(pc % DEPTH);
        return m_known[a] && m_known[(a+1)%DEPTH] && m_known[(a+2)%DEPTH] && m_known[(a+3)%DEPTH];
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] pc);
        int unsigned a = int'(pc % DEPTH);
        logic [31:0] w;
        w = 32'(m_mem[a]) * 32'h0100_0000 + 32'(m_mem[(a+1)%DEPTH]) * 32'h0001_0000
          + 32'(m_mem[(a+2)%DEPTH]) * 32'h0000_0100 + 32'(m_mem[(a+3)%DEPTH]);
        return w;
    endfunction

    logic [31:0] m_tgt;
    bit          m_idle;

    always @(posedge clk) begin
        if (i_reset || i_clear) begin
            m_running = 1'b0;
            m_halted  = 1'b0;
            m_pc      = 32'h0;
            m_ptr     = 0;
            if (i_reset) m_on = 1'b1;
        end else begin
            m_idle = !m_running && !m_halted;
            if (m_running && i_dunit_clk_en && i_PCWrite) begin
                if (!m_word_known(m_pc)) begin
                    failures++;
                    $display("FAIL model_fetch_unknown pc=%h", m_pc);
                end
                if (m_word(m_pc) == 32'hFFFF_FFFF) begin
                    m_running = 1'b0;
                    m_halted  = 1'b1;
                end else begin
                    if (i_JSel)       m_tgt = i_pc_jsel;
                    else if (i_Jump)  m_tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, i_inst_to_mxp} << 2);
                    else if (i_PCSrc) m_tgt = i_inmed;
                    else              m_tgt = m_pc + 32'd4;
                    m_pc = m_tgt & ~32'h3;
                end
            end
            if (m_idle && i_load_valid && m_ptr < DEPTH) begin
                m_mem[m_ptr]   = i_load_byte;
                m_known[m_ptr] = 1'b1;
                m_ptr++;
            end
            if (m_idle && i_start) m_running = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("pc", o_pc, m_pc);
            check("pcplus4", o_pcplus4, m_pc + 32'd4);
            check("halted", 32'(o_halted), 32'(m_halted));
            check("load_ready", 32'(o_load_ready), 32'(!m_running && !m_halted && m_ptr < DEPTH));
            check("load_full", 32'(o_load_full), 32'(m_ptr == DEPTH));
            check("load_count", 32'(o_load_count), 32'(m_ptr));
            if (!m_running)
                check("instruction_nop", o_instruction, 32'h0);
            else if (m_word_known(m_pc))
                check("instruction", o_instruction, m_word(m_pc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        i_load_valid = 1'b1;
        i_load_byte  = b;
        step();
        i_load_valid = 1'b0;
    endtask

    logic [7:0] prog [12];
    logic [7:0] img  [17];

    initial begin
        foreach (m_known[i]) m_known[i] = 1'b0;

        // Reset
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        @(negedge clk);
        check("t1_pc", o_pc, 32'h0);
        check("t1_pcplus4", o_pcplus4, 32'h4);
        check("t1_instr", o_instruction, 32'h0);
        check("t1_ready", 32'(o_load_ready), 32'h1);
        check("t1_count", 32'(o_load_count), 32'h0);

        // Load and run to HALT
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        i_dunit_clk_en = 1'b1;
        i_PCWrite      = 1'b1;
        for (int i = 0; i < 12; i++) load_byte(prog[i]);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        @(negedge clk);
        check("t2_c1_instr", o_instruction, 32'h2008_0005);
        check("t2_c1_pc", o_pc, 32'h0);
        step();
        @(negedge clk);
        check("t2_c2_instr", o_instruction, 32'h2009_0007);
        check("t2_c2_pc", o_pc, 32'h4);
        step();
        @(negedge clk);
        check("t2_c3_instr", o_instruction, 32'hFFFF_FFFF);
        step();
        step();
        @(negedge clk);
        check("t2_halted", 32'(o_halted), 32'h1);
        check("t2_halt_pc", o_pc, 32'h8);
        check("t2_halt_instr", o_instruction, 32'h0);

        // Clear out of HALTED
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        @(negedge clk);
        check("t6_clear_pc", o_pc, 32'h0);
        check("t6_clear_halted", 32'(o_halted), 32'h0);

        // Full / overflow: 17 valid bytes, 16 accepted
        img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 17; i++) load_byte(img[i]);
        @(negedge clk);
        check("t5_count", 32'(o_load_count), 32'd16);
        check("t5_full", 32'(o_load_full), 32'h1);
        check("t5_ready", 32'(o_load_ready), 32'h0);

        i_start = 1'b1;
        step();
        i_start = 1'b0;
        @(negedge clk);
        check("t5_run_instr", o_instruction, 32'hA1B2_C3D4);

        // Redirect priority
        i_JSel = 1'b1; i_Jump = 1'b1; i_PCSrc = 1'b1;
        i_pc_jsel = 32'h43; i_inmed = 32'h10; i_inst_to_mxp = 26'h155;
        step();
        @(negedge clk);
        check("t3_jsel_pc", o_pc, 32'h40);
        i_JSel = 1'b0; i_Jump = 1'b0;
        step();
        @(negedge clk);
        check("t3_pcsrc_pc", o_pc, 32'h10);

        // Wrap/alias fetch
        i_inmed = 32'h0C;
        step();
        @(negedge clk);
        check("t6_pc12", o_pc, 32'h0C);
        check("t6_word12", o_instruction, 32'h1122_3344);
        i_PCSrc = 1'b0; i_Jump = 1'b1; i_inst_to_mxp = 26'd4;
        step();
        @(negedge clk);
        check("t6_jump16_pc", o_pc, 32'h10);
        check("t6_alias_word", o_instruction, 32'hA1B2_C3D4);

        // Stall: PCWrite low, then clk_en low; the jump is lost
        i_inst_to_mxp = 26'd8;
        i_PCWrite = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("t4_pcwrite_hold", o_pc, 32'h10);
        i_PCWrite = 1'b1; i_dunit_clk_en = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("t4_clken_hold", o_pc, 32'h10);
        i_dunit_clk_en = 1'b1; i_Jump = 1'b0;
        step();
        @(negedge clk);
        check("t4_redirect_lost", o_pc, 32'h14);

        // Start is a no-op in RUN, then clear
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        @(negedge clk);
        check("t5_clear_count", 32'(o_load_count), 32'h0);
        check("t5_clear_ready", 32'(o_load_ready), 32'h1);

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            i_clear = 1'b1;
            step();
            i_clear = 1'b0;
            for (int b = 0; b < DEPTH; ) begin
                i_load_valid = ($urandom_range(0, 3) != 0);
                i_load_byte  = ((r % 2 == 1) && b >= 8 && b < 12) ? 8'hFF : 8'($urandom_range(0, 254));
                i_start      = i_load_valid && (b == DEPTH - 1) && (r % 3 == 0);
                step();
                if (i_load_valid) b++;
                i_load_valid = 1'b0;
                i_start      = 1'b0;
            end
            for (int c = 0; c < 80; c++) begin
                i_start        = ($urandom_range(0, 7) == 0);
                i_clear        = ($urandom_range(0, 40) == 0);
                i_dunit_clk_en = ($urandom_range(0, 3) != 0);
                i_PCWrite      = ($urandom_range(0, 3) != 0);
                i_JSel         = ($urandom_range(0, 7) == 0);
                i_Jump         = ($urandom_range(0, 7) == 0);
                i_PCSrc        = ($urandom_range(0, 3) == 0);
                i_inmed        = $urandom();
                i_pc_jsel      = $urandom();
                i_inst_to_mxp  = 26'($urandom());
                i_load_valid   = ($urandom_range(0, 3) == 0);
                i_load_byte    = 8'($urandom_range(0, 255));
                step();
            end
            i_start = 1'b0; i_clear = 1'b0; i_load_valid = 1'b0;
            i_JSel = 1'b0; i_Jump = 1'b0; i_PCSrc = 1'b0;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
